// File: rtl/issue_ctrl.sv
// Decode-to-execute issue controller: RAW scoreboard over EX/MEM, stall/flush handling, perf counters.
// Optional operand forwarding selects (and load-use-only stalls) when IC_FORWARD_EN is defined.

// Compares one decoded source operand against the EX and MEM scoreboard slots.
module ic_src_chk #(
    parameter int REG_SIZE = 5
) (
    input  logic                     use_src,
    input  logic [REG_SIZE-1:0]      src,
    input  logic [1:0]               s_vld,
    input  logic [1:0][REG_SIZE-1:0] s_dst,
    output logic [1:0]               hit
);
    always_comb begin
        for (int s = 0; s < 2; s++)
            hit[s] = use_src && (src != '0) && s_vld[s] && (s_dst[s] == src);
    end
endmodule

module issue_ctrl #(
    parameter int CODE_SIZE = 6,
    parameter int REG_SIZE  = 5,
    parameter int FUNC_SIZE = 11,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_SIZE-1:0] i_code,
    input  logic [REG_SIZE-1:0]  r_i,
    input  logic [REG_SIZE-1:0]  r_j,
    input  logic [REG_SIZE-1:0]  r_k,
    input  logic [FUNC_SIZE-1:0] i_func,
    input  logic                 flush,
    output logic                 issue_valid,
    output logic [CODE_SIZE-1:0] issue_code,
    output logic [REG_SIZE-1:0]  issue_ri,
    output logic [REG_SIZE-1:0]  issue_rj,
    output logic [REG_SIZE-1:0]  issue_rk,
    output logic [FUNC_SIZE-1:0] issue_func,
`ifdef IC_FORWARD_EN
    output logic [1:0]           fwd_j,
    output logic [1:0]           fwd_k,
`endif
    output logic                 illegal,
    output logic [CNT_SIZE-1:0]  stall_cnt,
    output logic [CNT_SIZE-1:0]  issue_cnt
);
    localparam logic [CODE_SIZE-1:0] OP_ALU = CODE_SIZE'(1);
    localparam logic [CODE_SIZE-1:0] OP_LW  = CODE_SIZE'(2);
    localparam logic [CODE_SIZE-1:0] OP_SW  = CODE_SIZE'(3);
    localparam int NSRC = 3;

    typedef struct packed {
        logic                vld;
        logic [REG_SIZE-1:0] dst;
        logic                ld;
    } slot_t;

    // Only EX and MEM are stored: the regfile is write-through, so a WB-stage
    // producer can never cause a hazard or need a forward.
    slot_t sb [2];

    logic is_alu, is_lw, is_sw, is_ill;
    logic hazard, accept, stall, writer;
    logic [NSRC-1:0]               use_src;
    logic [NSRC-1:0][REG_SIZE-1:0] src;
    logic [NSRC-1:0][1:0]          hit;
    logic [1:0]                    s_vld;
    logic [1:0][REG_SIZE-1:0]      s_dst;
    logic                          unused_ld;

    assign is_alu = (i_code == OP_ALU);
    assign is_lw  = (i_code == OP_LW);
    assign is_sw  = (i_code == OP_SW);
    assign is_ill = (i_code > OP_SW);

    // Source slots: 0 = r_i (SW data), 1 = r_j, 2 = r_k.
    assign use_src = {is_alu, is_alu | is_lw | is_sw, is_sw};
    assign src     = {r_k, r_j, r_i};
    assign s_vld   = {sb[1].vld, sb[0].vld};
    assign s_dst   = {sb[1].dst, sb[0].dst};
    assign unused_ld = sb[0].ld ^ sb[1].ld;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        ic_src_chk #(.REG_SIZE(REG_SIZE)) u_chk (
            .use_src(use_src[g]),
            .src    (src[g]),
            .s_vld  (s_vld),
            .s_dst  (s_dst),
            .hit    (hit[g])
        );
    end

`ifdef IC_FORWARD_EN
    logic [1:0] fsel_j, fsel_k;
    // Youngest producer (EX) takes priority over MEM.
    assign fsel_j = hit[1][0] ? 2'd1 : (hit[1][1] ? 2'd2 : 2'd0);
    assign fsel_k = hit[2][0] ? 2'd1 : (hit[2][1] ? 2'd2 : 2'd0);
    assign hazard = in_valid && sb[0].ld && (hit[0][0] || hit[1][0] || hit[2][0]);
`else
    assign hazard = in_valid && (|hit);
`endif

    assign in_ready = !hazard || flush;
    assign accept   = in_valid && in_ready && !flush;
    assign stall    = in_valid && !in_ready;
    assign writer   = accept && (is_alu || is_lw) && (r_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sb[0]       <= '0;
            sb[1]       <= '0;
            issue_valid <= 1'b0;
            issue_code  <= '0;
            issue_ri    <= '0;
            issue_rj    <= '0;
            issue_rk    <= '0;
            issue_func  <= '0;
            illegal     <= 1'b0;
            stall_cnt   <= '0;
            issue_cnt   <= '0;
`ifdef IC_FORWARD_EN
            fwd_j       <= 2'd0;
            fwd_k       <= 2'd0;
`endif
        end else begin
            sb[1]       <= sb[0];
            sb[0]       <= '{vld: writer, dst: r_i, ld: writer && is_lw};
            issue_valid <= accept;
            if (accept) begin
                issue_code <= i_code;
                issue_ri   <= r_i;
                issue_rj   <= r_j;
                issue_rk   <= r_k;
                issue_func <= i_func;
`ifdef IC_FORWARD_EN
                fwd_j      <= fsel_j;
                fwd_k      <= fsel_k;
`endif
                if (is_ill) illegal <= 1'b1;
                else        issue_cnt <= issue_cnt + 1'b1;
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl; expectations adapt to IC_FORWARD_EN. CNT_SIZE is shrunk so saturation/wrap are reachable.
module tb_issue_ctrl;
    localparam int CW = 6, RW = 5, FW = 11, NW = 4;
`ifdef IC_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, flush = 1'b0;
    logic in_ready;
    logic [CW-1:0] i_code = '0;
    logic [RW-1:0] r_i = '0, r_j = '0, r_k = '0;
    logic [FW-1:0] i_func = '0;
    logic issue_valid, illegal;
    logic [CW-1:0] issue_code;
    logic [RW-1:0] issue_ri, issue_rj, issue_rk;
    logic [FW-1:0] issue_func;
    logic [NW-1:0] stall_cnt, issue_cnt;
    logic [1:0] fwd_j, fwd_k;
    int vectors = 0, miscompares = 0;
    int st;

    always #5 clk = ~clk;

    issue_ctrl #(.CODE_SIZE(CW), .REG_SIZE(RW), .FUNC_SIZE(FW), .CNT_SIZE(NW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .i_code(i_code), .r_i(r_i), .r_j(r_j), .r_k(r_k), .i_func(i_func), .flush(flush),
        .issue_valid(issue_valid), .issue_code(issue_code), .issue_ri(issue_ri),
        .issue_rj(issue_rj), .issue_rk(issue_rk), .issue_func(issue_func),
`ifdef IC_FORWARD_EN
        .fwd_j(fwd_j), .fwd_k(fwd_k),
`endif
        .illegal(illegal), .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
    );
`ifndef IC_FORWARD_EN
    assign fwd_j = 2'd0;
    assign fwd_k = 2'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Present one instruction, wait (bounded) until accepted, return stall cycles seen.
    task automatic send(input int code, input int ri, input int rj, input int rk, input int fn,
                        output int stalls);
        i_code = CW'(code); r_i = RW'(ri); r_j = RW'(rj); r_k = RW'(rk); i_func = FW'(fn);
        in_valid = 1'b1;
        stalls = 0;
        #1;
        while (!in_ready && stalls < 8) begin
            tick();
            stalls++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        // reset state
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_issue_cnt", 32'(issue_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // back-to-back ALU dependency
        send(1, 1, 2, 3, 11'h2A5, st);
        chk("t2_first_stalls", 32'(st), 0);
        chk("t2_issue_valid", 32'(issue_valid), 1);
        chk("t2_issue_func", 32'(issue_func), 32'h2A5);
        send(1, 4, 1, 5, 7, st);
        chk("t2_stalls", 32'(st), FWD ? 0 : 2);
        chk("t2_stall_cnt", 32'(stall_cnt), FWD ? 0 : 2);
        chk("t2_issue_ri", 32'(issue_ri), 4);
        chk("t2_fwd_j", 32'(fwd_j), FWD ? 1 : 0);
        chk("t2_fwd_k", 32'(fwd_k), 0);

        // load-use
        idle(3);
        send(2, 1, 6, 0, 0, st);
        send(1, 2, 1, 1, 0, st);
        chk("t3_stalls", 32'(st), FWD ? 1 : 2);
        chk("t3_stall_cnt", 32'(stall_cnt), FWD ? 1 : 4);
        chk("t3_fwd_j", 32'(fwd_j), FWD ? 2 : 0);
        chk("t3_fwd_k", 32'(fwd_k), FWD ? 2 : 0);
        chk("t3_issue_cnt", 32'(issue_cnt), 4);

        // register 0 never hazards
        idle(3);
        send(1, 0, 1, 2, 0, st);
        send(1, 1, 0, 0, 0, st);
        chk("t4_stalls", 32'(st), 0);
        chk("t4_fwd_j", 32'(fwd_j), 0);
        chk("t4_fwd_k", 32'(fwd_k), 0);

        // flush with pending hazard (LW so both builds see a hazard)
        idle(3);
        send(2, 3, 1, 0, 0, st);
        i_code = 6'd1; r_i = 5'd5; r_j = 5'd3; r_k = 5'd3;
        in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("t5_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("t5_issue_valid", 32'(issue_valid), 0);
        chk("t5_stall_cnt", 32'(stall_cnt), FWD ? 1 : 4);
        chk("t5_issue_ri_held", 32'(issue_ri), 3);
        chk("t5_issue_cnt", 32'(issue_cnt), 7);

        // reset mid-stream
        send(1, 1, 2, 3, 0, st);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("t1_issue_valid", 32'(issue_valid), 0);
        chk("t1_issue_ri", 32'(issue_ri), 0);
        chk("t1_issue_code", 32'(issue_code), 0);
        chk("t1_stall_cnt", 32'(stall_cnt), 0);
        chk("t1_issue_cnt", 32'(issue_cnt), 0);
        send(1, 4, 1, 1, 0, st);
        chk("t1_dep_stalls", 32'(st), 0);
        chk("t1_dep_issue_cnt", 32'(issue_cnt), 1);

        // illegal opcode, sticky, not counted
        idle(3);
        send(7, 1, 2, 3, 0, st);
        chk("t6_ill_stalls", 32'(st), 0);
        chk("t6_ill_issue_valid", 32'(issue_valid), 1);
        chk("t6_illegal", 32'(illegal), 1);
        chk("t6_ill_issue_cnt", 32'(issue_cnt), 1);
        idle(2);
        chk("t6_illegal_sticky", 32'(illegal), 1);

        // stall_cnt saturates, issue_cnt wraps: 20 chained loads on r1
        for (int n = 0; n < 20; n++) send(2, 1, 1, 0, 0, st);
        chk("t6_stall_sat", 32'(stall_cnt), 15);
        chk("t6_issue_wrap", 32'(issue_cnt), 5);
        chk("t6_illegal_end", 32'(illegal), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
